mmm_seq_unit: RTL
=================

Name: mmm_seq_unit

Overview:
- Self-sequenced radix-2 bit-serial Montgomery modular multiplier computing R = A·B·2^-WIDTH mod M.
- Successor to the externally sequenced MMM datapath. It adds an internal FSM and iteration counter, a start/busy/done handshake, operand capture, an optional final conditional subtraction and an overflow-safe internal width.
- Sits under the RSA exponentiation controller, which issues one start per modular multiply (squaring or multiply step).

Parameters:
- WIDTH, 8, operand/modulus width in bits; iteration count = WIDTH; legal range ≥ 2.
- FINAL_SUB, 1, 1 = reduce result to [0, M); 0 = skip subtraction, result in [0, 2M), latency one cycle shorter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global enable; 0 freezes all state (FSM, counter, registers, done).
- start  input  1  operation request, sampled only when busy=0 and en=1.
- A  input  WIDTH  multiplicand; must be < M.
- B  input  WIDTH  multiplier; must be < M.
- M  input  WIDTH  modulus; must be odd.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; R is valid from this cycle.
- R  output  WIDTH  result register; holds its value until the next done or rst.

Behaviour:
- Reset (rst=1 at a clock edge, regardless of en): state=IDLE, counter=0, accumulator=0, R=0, busy=0, done=0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, ITER, SUB (present only if FINAL_SUB=1), DONE.
- IDLE:
  - On start=1 and en=1: latch A, B, M into internal registers.
  - Clear accumulator S (WIDTH+2 bits) and counter. Go to ITER; busy=1 from the next cycle.
  - Input changes after acceptance have no effect.
- ITER: one iteration per enabled cycle, i = counter, from 0 to WIDTH-1 (LSB of A first):
  - a_i = A_lat[i]
  - q = S[0] xor (a_i and B_lat[0])
  - S <= (S + (a_i ? B_lat : 0) + (q ? M_lat : 0)) >> 1
  - Sum is computed at WIDTH+2 bits; no truncation. Invariant S < 2M holds.
  - After iteration WIDTH-1: go to SUB if FINAL_SUB=1, else DONE.
- SUB:
  - If S ≥ M then S <= S - M, else S unchanged. Compare at full WIDTH+2 width.
  - Go to DONE.
- DONE:
  - R <= S[WIDTH-1:0], done=1 for exactly one cycle, busy=0.
  - Return to IDLE.
  - With FINAL_SUB=0, S may need WIDTH+1 bits when M ≥ 2^(WIDTH-1); the caller guarantees 2M < 2^WIDTH in that mode.
- Latency (en held 1): start accepted at edge 0 → done high after edge WIDTH+2 (FINAL_SUB=1) or WIDTH+1 (FINAL_SUB=0).
- Handshake:
  - start while busy=1 is ignored and not queued.
  - busy=0 during the done cycle, so start asserted in the done cycle is accepted, giving back-to-back operations with no idle gap.
- en=0 in any state stalls exactly: the cycle is not counted, and a done pulse pending at the stall is delayed, not lost or repeated.
- Domain violations (M even, A≥M or B≥M): R is unspecified, but the FSM still terminates with exactly one done at the nominal latency.
- Both adders and the subtractor are ripple-carry, parametrised by WIDTH+2. No multipliers.

Test Plan:
- WIDTH=4, FINAL_SUB=1, M=13, A=1, B=1, start one cycle → done exactly 6 cycles after acceptance, R=9. Intermediate S values after iterations 0-3: 7, 10, 5, 9.
- M=13, A=3, B=3 (Montgomery form of 1) → R=3. Then A=12, B=12 issued in the done cycle → accepted immediately, second done 6 cycles later, R=9.
- M=13, A=0, B=7 → R=0. FINAL_SUB=0 instance with M=13, A=1, B=1 → R=9 with done 5 cycles after acceptance.
- Stall: M=13, A=1, B=1, en=0 for 3 cycles in mid-ITER → done at cycle 9 instead of 6, R=9. start pulsed while busy → ignored, only one done.
- Reset: rst=1 at iteration 2 → next cycle busy=0, done=0, R=0. A new start (M=13, A=3, B=3) completes normally with R=3.
- WIDTH=8, M=239: random A, B < 239 over 1000 operations versus reference model (A·B·inv(256) mod 239). Check the R < M invariant and that done is always a single-cycle pulse.

Source files
------------

// File: rtl/mmm_seq_unit.sv
// mmm_seq_unit: self-sequenced radix-2 bit-serial Montgomery modular multiplier.
// Computes R = A * B * 2^-WIDTH mod M in WIDTH iterations, plus an optional final
// conditional subtraction, under a start/busy/done handshake.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high (overrides en)
//   en     - global enable; 0 freezes FSM, counter, operand/result registers and done
//   start  - operation request, sampled only while idle and enabled
//   A, B   - operands (must be < M)
//   M      - modulus (must be odd)
//   busy   - high while an operation is in flight
//   done   - one-cycle pulse; R is valid from this cycle
//   R      - result register, held until the next done or reset
module mmm_seq_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          FINAL_SUB = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  // Accumulator width: S < 2M plus one bit of headroom for the pre-shift sum.
  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StIter, StSub, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    s_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH-1:0] r_q;
  logic             done_q;

  // Ripple-carry adder over SW+1 bits; the extra top bit keeps every carry visible.
  function automatic logic [SW:0] rca(input logic [SW:0] x, input logic [SW:0] y,
                                      input logic cin);
    logic [SW:0] s;
    logic        c;
    c = cin;
    for (int k = 0; k <= int'(SW); k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    return s;
  endfunction

  // Datapath
  logic          a_bit, q_bit, last_iter;
  logic [SW:0]   b_ext, m_ext, sum1, sum2, diff;
  logic [SW-1:0] s_iter, s_sub;

  always_comb begin
    a_bit     = a_q[cnt_q];
    q_bit     = s_q[0] ^ (a_bit & b_q[0]);
    b_ext     = {3'b000, b_q};
    m_ext     = {3'b000, m_q};
    sum1      = rca({1'b0, s_q}, a_bit ? b_ext : '0, 1'b0);
    sum2      = rca(sum1, q_bit ? m_ext : '0, 1'b0);
    // The sum is even by construction of q, so the shift drops nothing.
    s_iter    = sum2[SW:1];
    // S - M over SW+1 bits; the top bit is set exactly when S < M.
    diff      = rca({1'b0, s_q}, ~m_ext, 1'b1);
    s_sub     = diff[SW] ? s_q : diff[SW-1:0];
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StIter;
      StIter: if (last_iter) state_d = FINAL_SUB ? StSub : StDone;
      StSub:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    R    = r_q;
  end

  // Operand capture, accumulator, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      s_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            m_q   <= M;
            s_q   <= '0;
            cnt_q <= '0;
          end
        end
        StIter: begin
          s_q   <= s_iter;
          cnt_q <= cnt_q + 1'b1;
        end
        StSub: s_q <= s_sub;
        StDone: begin
          r_q    <= s_q[WIDTH-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
